// File: rtl/rate_tick_gen.sv
// Programmable rate divider: one-cycle tick every (divisor+1) clocks, periodic or one-shot,
// with a modulo tick counter. Define RATE_TICK_SQ_EN to enable the square-wave output on sq.
module rate_tick_gen #(
  parameter int          WIDTH       = 28,
  parameter int unsigned DEFAULT_DIV = 50_000_000,
  parameter int          TICK_MOD    = 60,
  parameter int          CW          = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             mode,
  input  logic             start,
  input  logic             div_wr,
  input  logic [WIDTH-1:0] div_in,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] q,
  output logic [CW-1:0]    tick_count,
  output logic             wrap,
  output logic             sq
);

  localparam logic [WIDTH-1:0] DEF_DIV   = WIDTH'(DEFAULT_DIV);
  localparam logic [CW-1:0]    LAST_TICK = CW'(TICK_MOD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] div_reg;
  logic [WIDTH-1:0] q_reg;
  logic [CW-1:0]    count_reg;
  logic             tick_reg;
  logic             wrap_reg;
  logic [WIDTH-1:0] div_load;
  logic             restart;
  logic             terminal;

  // A write landing on a reload edge takes effect immediately.
  assign div_load = div_wr ? div_in : div_reg;
  assign restart  = (state_reg == RUN) && start && mode;
  assign terminal = (state_reg == RUN) && !restart && enable && (q_reg == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      div_reg   <= DEF_DIV;
      q_reg     <= DEF_DIV;
      count_reg <= '0;
      tick_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      tick_reg <= 1'b0;
      wrap_reg <= 1'b0;
      if (div_wr) begin
        div_reg <= div_in;
      end
      case (state_reg)
        IDLE: begin
          q_reg <= div_load;
          if (start || (!mode && enable)) begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (restart) begin
            q_reg <= div_load;
          end else if (terminal) begin
            tick_reg <= 1'b1;
            q_reg    <= div_load;
            if (count_reg == LAST_TICK) begin
              count_reg <= '0;
              wrap_reg  <= 1'b1;
            end else begin
              count_reg <= count_reg + CW'(1);
            end
            if (mode) begin
              state_reg <= IDLE;
            end
          end else if (enable) begin
            q_reg <= q_reg - WIDTH'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef RATE_TICK_SQ_EN
  logic sq_reg;

  // Toggles once per tick, so the half-period equals the tick period.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sq_reg <= 1'b0;
    end else if (terminal) begin
      sq_reg <= ~sq_reg;
    end
  end

  assign sq = sq_reg;
`else
  assign sq = 1'b0;
`endif

  assign tick       = tick_reg;
  assign wrap       = wrap_reg;
  assign busy       = (state_reg == RUN);
  assign q          = q_reg;
  assign tick_count = count_reg;

endmodule
